// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - two-entry in-order immediate extension buffer
//
// Purpose: extends an instruction immediate field according to in_mode at
// acceptance and holds up to two results in arrival order.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   flush             synchronous discard of all held entries and offered transfers
//   in_valid/in_ready request handshake; in_ready depends only on held state
//   in_mode           extension mode (0..6 defined, 7 reserved)
//   in_imm16/26/5     immediate source fields
//   in_tag            opaque sideband returned with the result
//   out_valid/ready   result handshake
//   out_data          extended immediate of the oldest entry
//   out_tag, out_err  tag and reserved-mode flag of the oldest entry
//   occ               number of held entries, 0..2

module imm_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [15:0]       in_imm16,
    input  logic [25:0]       in_imm26,
    input  logic [4:0]        in_imm5,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [1:0]        occ
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("imm_ext_pipe: DATA_W must be 32 or 64");
    end

    // Slot 0 is always the head; slot 1 only holds data when occ == 2.
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] s0_data_q, s0_data_d, s1_data_q, s1_data_d;
    logic [TAG_W-1:0]  s0_tag_q, s0_tag_d, s1_tag_q, s1_tag_d;
    logic              s0_err_q, s0_err_d, s1_err_q, s1_err_d;

    logic [DATA_W-1:0] ext_data;
    logic              ext_err;
    logic              push, pop;

    // Size casts of signed operands sign-extend, unsigned ones zero-extend,
    // so one expression per mode covers both DATA_W values.
    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_mode)
            3'd0:    ext_data = DATA_W'(in_imm16);
            3'd1:    ext_data = DATA_W'($signed(in_imm16));
            3'd2:    ext_data = DATA_W'($signed({in_imm16, 16'h0000}));
            3'd3:    ext_data = DATA_W'(in_imm26);
            3'd4:    ext_data = DATA_W'(in_imm5);
            3'd5:    ext_data = DATA_W'($signed({in_imm16, 2'b00}));
            3'd6:    ext_data = DATA_W'({in_imm26, 2'b00});
            default: ext_err  = 1'b1;
        endcase
    end

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_d     = occ_q;
        s0_data_d = s0_data_q;
        s0_tag_d  = s0_tag_q;
        s0_err_d  = s0_err_q;
        s1_data_d = s1_data_q;
        s1_tag_d  = s1_tag_q;
        s1_err_d  = s1_err_q;
        if (flush) begin
            // Slot contents become stale but are hidden by out_valid = 0.
            occ_d = 2'd0;
        end else if (push && pop) begin
            // push is only possible with occ <= 1, so the head is the only
            // entry and the new one replaces it directly.
            s0_data_d = ext_data;
            s0_tag_d  = in_tag;
            s0_err_d  = ext_err;
        end else if (pop) begin
            s0_data_d = s1_data_q;
            s0_tag_d  = s1_tag_q;
            s0_err_d  = s1_err_q;
            occ_d     = occ_q - 2'd1;
        end else if (push) begin
            if (occ_q == 2'd0) begin
                s0_data_d = ext_data;
                s0_tag_d  = in_tag;
                s0_err_d  = ext_err;
            end else begin
                s1_data_d = ext_data;
                s1_tag_d  = in_tag;
                s1_err_d  = ext_err;
            end
            occ_d = occ_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q     <= 2'd0;
            s0_data_q <= '0;
            s0_tag_q  <= '0;
            s0_err_q  <= 1'b0;
            s1_data_q <= '0;
            s1_tag_q  <= '0;
            s1_err_q  <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            s0_data_q <= s0_data_d;
            s0_tag_q  <= s0_tag_d;
            s0_err_q  <= s0_err_d;
            s1_data_q <= s1_data_d;
            s1_tag_q  <= s1_tag_d;
            s1_err_q  <= s1_err_d;
        end
    end

    assign out_data = s0_data_q;
    assign out_tag  = s0_tag_q;
    assign out_err  = s0_err_q;
    assign occ      = occ_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - self-checking bench for imm_ext_pipe
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_mode = '0;
    logic [15:0] in_imm16 = '0;
    logic [25:0] in_imm26 = '0;
    logic [4:0]  in_imm5 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;
    logic [1:0]  occ;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [2:0]  w_in_mode = '0;
    logic [15:0] w_in_imm16 = '0;
    logic [25:0] w_in_imm26 = '0;
    logic        w_out_valid;
    logic [63:0] w_out_data;
    logic [4:0]  w_out_tag;
    logic        w_out_err;
    logic [1:0]  w_occ;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } ent_t;
    ent_t mq[$];

    logic [31:0] sweep [8];

    always #5 clk = ~clk;

    imm_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_imm16(in_imm16), .in_imm26(in_imm26), .in_imm5(in_imm5),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_err(out_err), .occ(occ)
    );

    imm_ext_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_mode(w_in_mode),
        .in_imm16(w_in_imm16), .in_imm26(w_in_imm26), .in_imm5(5'd0),
        .in_tag(5'd0), .out_valid(w_out_valid), .out_ready(1'b1),
        .out_data(w_out_data), .out_tag(w_out_tag), .out_err(w_out_err), .occ(w_occ)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference extension from the mode rules using plain integer arithmetic.
    function automatic logic [63:0] ref_ext(input int mode, input int i16, input int i26,
                                            input int i5, input int w, output logic err);
        longint v;
        err = 1'b0;
        case (mode)
            0: v = i16;
            1: v = (i16 >= 32768) ? i16 - 65536 : i16;
            2: begin
                v = longint'(i16) * 65536;
                if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
            end
            3: v = i26;
            4: v = i5;
            5: begin
                v = longint'(i16) * 4;
                if (v >= 131072) v = v - 262144;
            end
            6: v = longint'(i26) * 4;
            default: begin
                v = 0;
                err = 1'b1;
            end
        endcase
        if (w == 32) v = v & 64'h00000000FFFFFFFF;
        return v;
    endfunction

    // One clock: predict transfers from the offered inputs, advance, then
    // compare the DUT against the model queue.
    task automatic cycle();
        bit   do_push, do_pop;
        ent_t e;
        logic [63:0] v;
        logic er;
        do_push = in_valid && (mq.size() < 2) && !flush;
        do_pop  = out_ready && (mq.size() > 0) && !flush;
        v = ref_ext(int'(in_mode), int'(in_imm16), int'(in_imm26), int'(in_imm5), 32, er);
        e.data = v[31:0];
        e.tag  = in_tag;
        e.err  = er;
        @(posedge clk);
        #1;
        if (flush) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        chk("occ", occ, mq.size());
        chk("out_valid", out_valid, mq.size() != 0);
        chk("in_ready", in_ready, mq.size() != 2);
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_tag", out_tag, mq[0].tag);
            chk("out_err", out_err, mq[0].err);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [4:0] t, input logic r);
        in_valid  = v;
        in_mode   = m;
        in_tag    = t;
        out_ready = r;
    endtask

    initial begin
        sweep = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'h03FFFFFF,
                  32'h0000001F, 32'hFFFE0004, 32'h0FFFFFFC, 32'h00000000};

        // Reset state
        #1;
        chk("rst_occ", occ, 2'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_tag", out_tag, 5'd0);
        chk("rst_out_err", out_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 64-bit instance, main DUT idle
        w_in_valid = 1'b1;
        w_in_mode  = 3'd2;
        w_in_imm16 = 16'h8000;
        @(posedge clk);
        #1;
        chk("w64_lui_valid", w_out_valid, 1'b1);
        chk("w64_lui", w_out_data, 64'hFFFFFFFF80000000);
        w_in_mode  = 3'd6;
        w_in_imm26 = 26'h3FFFFFF;
        @(posedge clk);
        #1;
        chk("w64_j28", w_out_data, 64'h000000000FFFFFFC);
        chk("w64_j28_err", w_out_err, 1'b0);
        w_in_valid = 1'b0;

        // Mode sweep at full rate
        in_imm16 = 16'h8001;
        in_imm26 = 26'h3FFFFFF;
        in_imm5  = 5'd31;
        for (int m = 0; m < 8; m++) begin
            drive(1'b1, 3'(m), 5'(m), 1'b1);
            cycle();
            chk("sweep_data", out_data, sweep[m]);
            chk("sweep_err", out_err, m == 7);
        end
        drive(1'b0, 3'd0, 5'd0, 1'b1);
        cycle();

        // Backpressure
        drive(1'b1, 3'd1, 5'd1, 1'b0);
        cycle();
        in_tag = 5'd2;
        cycle();
        in_tag = 5'd3;
        cycle();
        chk("bp_occ", occ, 2'd2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_head_tag", out_tag, 5'd1);
        drive(1'b0, 3'd0, 5'd0, 1'b1);
        cycle();
        chk("bp_pop2_tag", out_tag, 5'd2);
        cycle();
        chk("bp_empty", occ, 2'd0);

        // Full-rate streaming, tags 0..9
        for (int t = 0; t < 10; t++) begin
            drive(1'b1, 3'd0, 5'(t), 1'b1);
            in_imm16 = 16'(t * 321);
            cycle();
            chk("stream_occ", occ, 2'd1);
            chk("stream_tag", out_tag, 5'(t));
        end
        drive(1'b0, 3'd0, 5'd0, 1'b1);
        cycle();

        // Flush with two held entries and a valid input
        drive(1'b1, 3'd3, 5'd4, 1'b0);
        cycle();
        in_tag = 5'd5;
        cycle();
        chk("fl_pre_occ", occ, 2'd2);
        drive(1'b1, 3'd4, 5'd7, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_occ", occ, 2'd0);
        chk("fl_out_valid", out_valid, 1'b0);
        drive(1'b0, 3'd0, 5'd0, 1'b1);
        cycle();
        cycle();
        chk("fl_no_stale", out_valid, 1'b0);

        // Reset between edges with two held entries
        drive(1'b1, 3'd5, 5'd10, 1'b0);
        cycle();
        in_tag = 5'd11;
        cycle();
        #1;
        reset = 1'b1;
        #1;
        chk("mr_occ", occ, 2'd0);
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_in_ready", in_ready, 1'b1);
        chk("mr_out_data", out_data, 32'h0);
        chk("mr_out_tag", out_tag, 5'd0);
        chk("mr_out_err", out_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        drive(1'b1, 3'd1, 5'd9, 1'b0);
        in_imm16 = 16'hFFFE;
        cycle();
        chk("mr_after_valid", out_valid, 1'b1);
        chk("mr_after_tag", out_tag, 5'd9);
        chk("mr_after_data", out_data, 32'hFFFFFFFE);
        drive(1'b0, 3'd0, 5'd0, 1'b1);
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  5'($urandom), 1'($urandom_range(0, 1)));
            in_imm16 = 16'($urandom);
            in_imm26 = 26'($urandom);
            in_imm5  = 5'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
